// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and defaults for the unified memory port arbiter
package mem_arb_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  typedef enum logic {OWNER_INSTR = 1'b0, OWNER_DATA = 1'b1} owner_t;
  localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: ISSUE-cycle counter flagging the last cycle allowed before abort
module mem_arb_timer #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam logic [CNT_W-1:0] last = CNT_W'(LIMIT - 1);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt <= '0;
    else if (clr_i) cnt <= '0;
    else if (en_i) cnt <= cnt + CNT_W'(1);
  // cnt holds completed cycles, so the LIMIT-th ISSUE cycle is the one that expires
  assign expired_o = en_i && (cnt == last);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between fetch and data, data first
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ready_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              err_o
);
  logic [1:0] state;
  owner_t owner;
  logic expired;
  logic [DATA_W-1:0] done_data;
  mem_arb_timer #(.CNT_W(CNT_W), .LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(state != S_ISSUE),
    .en_i(state == S_ISSUE),
    .expired_o(expired)
  );
  // writes and aborted transfers hand back zero
  assign done_data = (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state       <= S_IDLE;
      owner       <= OWNER_INSTR;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE:
          if (dm_req_i) begin
            state       <= S_ISSUE;
            owner       <= OWNER_DATA;
            mem_req_o   <= 1'b1;
            mem_we_o    <= dm_we_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
          end else if (if_req_i) begin
            state      <= S_ISSUE;
            owner      <= OWNER_INSTR;
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= if_addr_i;
          end
        S_ISSUE:
          if (mem_ack_i || expired) begin
            state     <= S_RESP;
            mem_req_o <= 1'b0;
            if (owner == OWNER_DATA) dm_rdata_o <= done_data;
            else if_rdata_o <= done_data;
            if (!mem_ack_i) err_o <= 1'b1;
          end
        default: state <= S_IDLE;
      endcase
    end
  assign if_ready_o = (state == S_RESP) && (owner == OWNER_INSTR);
  assign dm_ready_o = (state == S_RESP) && (owner == OWNER_DATA);
  assign stall_o    = (if_req_i && !if_ready_o) || (dm_req_i && !dm_ready_o);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, reset sequences and random traffic against a cycle-timing model
module tb_mem_port_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic if_req_i = 1'b0, dm_req_i = 1'b0, dm_we_i = 1'b0, mem_ack_i = 1'b0;
  logic [31:0] if_addr_i = '0, dm_addr_i = '0, dm_wdata_i = '0, mem_rdata_i = '0;
  logic if_ready_o, dm_ready_o, mem_req_o, mem_we_o, stall_o, err_o;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  int checks = 0;
  int errors = 0;
  logic [31:0] m_if_rdata = '0, m_dm_rdata = '0;
  logic m_err = 1'b0;
  typedef struct {
    logic do_dm, do_if, we;
    logic [31:0] dm_addr, wdata, if_addr, dm_rd, if_rd;
    int lat_dm, lat_if;
    logic [31:0] exp_dm, exp_if;
    logic exp_err;
  } vec_t;
  vec_t tbl[6];
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ready_o(if_ready_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ready_o(dm_ready_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o), .err_o(err_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_cleared(input string tag);
    chk({tag, "_mem_req"}, mem_req_o, 0);
    chk({tag, "_mem_we"}, mem_we_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
    chk({tag, "_if_ready"}, if_ready_o, 0);
    chk({tag, "_dm_ready"}, dm_ready_o, 0);
    chk({tag, "_if_rdata"}, if_rdata_o, 0);
    chk({tag, "_dm_rdata"}, dm_rdata_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask
  task automatic rst_pulse();
    @(posedge clk); #1;
    rst_i = 1'b0;
    #1 check_cleared("rst_pulse");
    @(posedge clk); #1;
    rst_i = 1'b1;
    m_if_rdata = '0;
    m_dm_rdata = '0;
    m_err = 1'b0;
  endtask
  // Expected timing: data granted at cycle 0 when present; each transfer spends
  // min(lat,TO) cycles in ISSUE, one RESP cycle, and the next grant follows one idle cycle later.
  task automatic group(input vec_t v, input bit stray);
    int e_dm, e_if, g_dm, g_if, r_dm, r_if, fin;
    bit ack_dm, ack_if, iss_dm, iss_if;
    e_dm = v.lat_dm > TO ? TO : v.lat_dm;
    e_if = v.lat_if > TO ? TO : v.lat_if;
    g_dm = v.do_dm ? 0 : -100;
    r_dm = v.do_dm ? e_dm + 1 : -100;
    g_if = v.do_dm ? r_dm + 1 : 0;
    r_if = v.do_if ? g_if + e_if + 1 : -100;
    fin = (r_dm > r_if ? r_dm : r_if) + 1;
    for (int c = 0; c <= fin; c++) begin
      @(posedge clk); #1;
      dm_req_i = v.do_dm && c <= r_dm;
      dm_we_i = v.we;
      dm_addr_i = v.dm_addr;
      dm_wdata_i = v.wdata;
      if_req_i = v.do_if && c <= r_if;
      if_addr_i = v.if_addr;
      ack_dm = v.do_dm && c == g_dm + v.lat_dm;
      ack_if = v.do_if && c == g_if + v.lat_if;
      mem_ack_i = ack_dm || ack_if || (stray && (c == 0 || c == fin));
      mem_rdata_i = ack_dm ? v.dm_rd : ack_if ? v.if_rd : $urandom;
      @(negedge clk);
      iss_dm = v.do_dm && c > g_dm && c <= g_dm + e_dm;
      iss_if = v.do_if && c > g_if && c <= g_if + e_if;
      chk("mem_req", mem_req_o, iss_dm || iss_if);
      if (iss_dm) begin
        chk("mem_addr_dm", mem_addr_o, v.dm_addr);
        chk("mem_we_dm", mem_we_o, v.we);
        if (v.we) chk("mem_wdata", mem_wdata_o, v.wdata);
      end
      if (iss_if) begin
        chk("mem_addr_if", mem_addr_o, v.if_addr);
        chk("mem_we_if", mem_we_o, 0);
      end
      if (v.do_dm && c == r_dm) begin
        m_dm_rdata = v.exp_dm;
        m_err = m_err | (v.lat_dm > TO);
      end
      if (v.do_if && c == r_if) begin
        m_if_rdata = v.exp_if;
        m_err = m_err | (v.lat_if > TO);
      end
      chk("dm_ready", dm_ready_o, v.do_dm && c == r_dm);
      chk("if_ready", if_ready_o, v.do_if && c == r_if);
      chk("stall", stall_o, (v.do_dm && c < r_dm) || (v.do_if && c < r_if));
      chk("dm_rdata", dm_rdata_o, m_dm_rdata);
      chk("if_rdata", if_rdata_o, m_if_rdata);
      chk("err", err_o, m_err);
    end
    mem_ack_i = 1'b0;
    chk("err_final", err_o, v.exp_err);
  endtask
  initial begin
    vec_t v;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h20080005, 0, 3, 32'h0, 32'h20080005, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'h200, 32'hDEADBEEF, 32'h12345678, 2, 1, 32'hDEADBEEF, 32'h12345678, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, 32'h0, 32'hFFFF0000, 32'h0, 1, 0, 32'h0, 32'h0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h10, 32'h0, 32'h77, 0, TO, 32'h0, 32'h77, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 32'h11111111, 32'h0, 9, 0, 32'h0, 32'h0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h14, 32'h0, 32'hCAFEF00D, 0, 2, 32'h0, 32'hCAFEF00D, 1'b1};
    #2 check_cleared("por");
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
    // reset while a fetch is in ISSUE, then a late ack that must be ignored
    @(posedge clk); #1;
    if_req_i = 1'b1;
    if_addr_i = 32'h40;
    @(negedge clk);
    chk("mid_rst_idle_req", mem_req_o, 0);
    chk("mid_rst_stall", stall_o, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_issue_req", mem_req_o, 1);
    chk("mid_rst_issue_addr", mem_addr_o, 32'h40);
    #1 rst_i = 1'b0;
    #1 chk("mid_rst_req_drop", mem_req_o, 0);
    if_req_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h55;
    @(negedge clk);
    chk("late_ack_if_ready", if_ready_o, 0);
    chk("late_ack_dm_ready", dm_ready_o, 0);
    chk("late_ack_mem_req", mem_req_o, 0);
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("late_ack_if_ready2", if_ready_o, 0);
    chk("late_ack_if_rdata", if_rdata_o, 0);
    chk("late_ack_err", err_o, 0);
    for (int i = 0; i < 6; i++) group(tbl[i], i == 3);
    rst_pulse();
    for (int i = 0; i < 80; i++) begin
      v.do_dm = 1'($urandom_range(0, 1));
      v.do_if = 1'($urandom_range(0, 1));
      if (!v.do_dm && !v.do_if) v.do_if = 1'b1;
      v.we = 1'($urandom_range(0, 1));
      v.dm_addr = $urandom;
      v.wdata = $urandom;
      v.if_addr = $urandom;
      v.dm_rd = $urandom;
      v.if_rd = $urandom;
      v.lat_dm = $urandom_range(1, 6);
      v.lat_if = $urandom_range(1, 6);
      v.exp_dm = (v.lat_dm > TO || v.we) ? 32'h0 : v.dm_rd;
      v.exp_if = v.lat_if > TO ? 32'h0 : v.if_rd;
      v.exp_err = m_err | (v.do_dm && v.lat_dm > TO) | (v.do_if && v.lat_if > TO);
      group(v, 1'($urandom_range(0, 1)));
    end
    rst_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
